// File: rtl/unproject3.sv
// unproject3: rebuilds world-space x = xs*z, y = ys*z from a projected point and depth with
// an iterative shift-add multiplier. Define UNPROJECT3_ROUND_EN to round half away from zero.
module unproject3 #(
    parameter int integerBits  = 6,
    parameter int fractionBits = 25,
    parameter int reduction    = 12,
    localparam int totalBits   = 1 + integerBits + fractionBits - reduction,
    localparam int productBits = 2 * totalBits
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        inValid_i,
    output logic                        inReady_o,
    input  logic signed [totalBits-1:0] xsIn_i,
    input  logic signed [totalBits-1:0] ysIn_i,
    input  logic signed [totalBits-1:0] zIn_i,
    output logic                        outValid_o,
    input  logic                        outReady_i,
    output logic signed [totalBits-1:0] xOut_o,
    output logic signed [totalBits-1:0] yOut_o,
    output logic                        zErr_o,
    output logic                        sat_o
);

    localparam int CntW = $clog2(totalBits);
    localparam logic [productBits-1:0] MaxMag =
        {{(productBits-totalBits+1){1'b0}}, {(totalBits-1){1'b1}}};
`ifdef UNPROJECT3_ROUND_EN
    localparam logic [productBits-1:0] RoundBias =
        {{(productBits-1){1'b0}}, 1'b1} << (fractionBits-1);
`endif

    typedef enum logic [1:0] {IDLE, MUL, FINISH, DONE} state_t;

    state_t                       state_q, state_d;
    logic [totalBits-1:0]         magX_q, magX_d, magY_q, magY_d;
    logic                         signX_q, signX_d, signY_q, signY_d;
    logic signed [totalBits-1:0]  z_q, z_d;
    logic [productBits-1:0]       accX_q, accX_d, accY_q, accY_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic signed [totalBits-1:0]  xOut_q, xOut_d, yOut_q, yOut_d;
    logic                         zErr_q, zErr_d, sat_q, sat_d;
    logic                         outValid_q, outValid_d;
    logic [totalBits:0]           scaledX, scaledY;

    // Drops the fraction bits of a product magnitude and clamps it; MSB of the result flags saturation.
    function automatic logic [totalBits:0] scaleMag(input logic [productBits-1:0] acc);
        logic [productBits-1:0] v;
        v = acc;
`ifdef UNPROJECT3_ROUND_EN
        v = v + RoundBias;
`endif
        v = v >> fractionBits;
        if (v > MaxMag) begin
            return {1'b1, MaxMag[totalBits-1:0]};
        end
        return {1'b0, v[totalBits-1:0]};
    endfunction

    assign scaledX = scaleMag(accX_q);
    assign scaledY = scaleMag(accY_q);

    always_comb begin
        state_d    = state_q;
        magX_d     = magX_q;
        magY_d     = magY_q;
        signX_d    = signX_q;
        signY_d    = signY_q;
        z_d        = z_q;
        accX_d     = accX_q;
        accY_d     = accY_q;
        cnt_d      = cnt_q;
        xOut_d     = xOut_q;
        yOut_d     = yOut_q;
        zErr_d     = zErr_q;
        sat_d      = sat_q;
        outValid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (inValid_i) begin
                    magX_d  = xsIn_i[totalBits-1] ? -xsIn_i : xsIn_i;
                    magY_d  = ysIn_i[totalBits-1] ? -ysIn_i : ysIn_i;
                    signX_d = xsIn_i[totalBits-1];
                    signY_d = ysIn_i[totalBits-1];
                    z_d     = zIn_i;
                    accX_d  = '0;
                    accY_d  = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (z_q[cnt_q]) begin
                    accX_d = accX_q + ({{(productBits-totalBits){1'b0}}, magX_q} << cnt_q);
                    accY_d = accY_q + ({{(productBits-totalBits){1'b0}}, magY_q} << cnt_q);
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(totalBits-1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                xOut_d = signX_q ? -scaledX[totalBits-1:0] : scaledX[totalBits-1:0];
                yOut_d = signY_q ? -scaledY[totalBits-1:0] : scaledY[totalBits-1:0];
                sat_d  = scaledX[totalBits] | scaledY[totalBits];
                zErr_d = 1'b0;
                // A non-positive depth has no meaningful reconstruction.
                if (z_q <= 0) begin
                    xOut_d = '0;
                    yOut_d = '0;
                    sat_d  = 1'b0;
                    zErr_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                // Valid trails DONE entry by one cycle so results are settled before being offered.
                outValid_d = 1'b1;
                if (outValid_q && outReady_i) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            magX_q     <= '0;
            magY_q     <= '0;
            signX_q    <= 1'b0;
            signY_q    <= 1'b0;
            z_q        <= '0;
            accX_q     <= '0;
            accY_q     <= '0;
            cnt_q      <= '0;
            xOut_q     <= '0;
            yOut_q     <= '0;
            zErr_q     <= 1'b0;
            sat_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            magX_q     <= magX_d;
            magY_q     <= magY_d;
            signX_q    <= signX_d;
            signY_q    <= signY_d;
            z_q        <= z_d;
            accX_q     <= accX_d;
            accY_q     <= accY_d;
            cnt_q      <= cnt_d;
            xOut_q     <= xOut_d;
            yOut_q     <= yOut_d;
            zErr_q     <= zErr_d;
            sat_q      <= sat_d;
            outValid_q <= outValid_d;
        end
    end

    assign inReady_o  = (state_q == IDLE);
    assign outValid_o = outValid_q;
    assign xOut_o     = xOut_q;
    assign yOut_o     = yOut_q;
    assign zErr_o     = zErr_q;
    assign sat_o      = sat_q;

endmodule

// File: tb/tb_unproject3.sv
// Directed-vector bench for unproject3: a default build instance plus a fractionBits=8 instance
// (integerBits widened to keep 20-bit words) for the saturation case.
module tb_unproject3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [19:0] xsIn = '0, ysIn = '0, zIn = '0;
    logic inValidA = 1'b0, outReadyA = 1'b1, inReadyA, outValidA, zErrA, satA;
    logic inValidB = 1'b0, outReadyB = 1'b1, inReadyB, outValidB, zErrB, satB;
    logic signed [19:0] xOutA, yOutA, xOutB, yOutB;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        logic signed [19:0] xs, ys, z, expX, expY;
        logic expZErr, expSat;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    unproject3 dutA (
        .clk_i(clk), .reset_i(reset), .inValid_i(inValidA), .inReady_o(inReadyA),
        .xsIn_i(xsIn), .ysIn_i(ysIn), .zIn_i(zIn), .outValid_o(outValidA),
        .outReady_i(outReadyA), .xOut_o(xOutA), .yOut_o(yOutA), .zErr_o(zErrA), .sat_o(satA)
    );

    unproject3 #(.integerBits(23), .fractionBits(8), .reduction(12)) dutB (
        .clk_i(clk), .reset_i(reset), .inValid_i(inValidB), .inReady_o(inReadyB),
        .xsIn_i(xsIn), .ysIn_i(ysIn), .zIn_i(zIn), .outValid_o(outValidB),
        .outReady_i(outReadyB), .xOut_o(xOutB), .yOut_o(yOutB), .zErr_o(zErrB), .sat_o(satB)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offers one triple to the selected instance and returns the edges from accept to outValid.
    task automatic applyStimulus(input bit useB, input logic signed [19:0] xs, ys, z,
                                 output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(useB ? inReadyB : inReadyA) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("inReady before offer", longint'(useB ? inReadyB : inReadyA), 1);
        xsIn = xs;
        ysIn = ys;
        zIn  = z;
        if (useB) inValidB = 1'b1; else inValidA = 1'b1;
        @(posedge clk);
        #1;
        inValidA = 1'b0;
        inValidB = 1'b0;
        lat = 0;
        while (!(useB ? outValidB : outValidA) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkResult(input string tag, input bit useB, input vec_t v, input int lat);
        checkOutput({tag, " latency"}, lat, 22);
        checkOutput({tag, " xOut"}, useB ? xOutB : xOutA, v.expX);
        checkOutput({tag, " yOut"}, useB ? yOutB : yOutA, v.expY);
        checkOutput({tag, " zErr"}, useB ? zErrB : zErrA, v.expZErr);
        checkOutput({tag, " sat"}, useB ? satB : satA, v.expSat);
    endtask

    initial begin
        int lat;
        int seenValid;
        vec_t satVec;

`ifdef UNPROJECT3_ROUND_EN
        vecs[0] = '{xs: 335544, ys: -335544, z: 1000, expX: 10, expY: -10, expZErr: 0, expSat: 0};
        vecs[1] = '{xs: 0, ys: 524287, z: 524287, expX: 0, expY: 8192, expZErr: 0, expSat: 0};
        vecs[4] = '{xs: -524288, ys: 524287, z: 524287, expX: -8192, expY: 8192, expZErr: 0, expSat: 0};
        vecs[5] = '{xs: 65536, ys: -32768, z: 512, expX: 1, expY: -1, expZErr: 0, expSat: 0};
`else
        vecs[0] = '{xs: 335544, ys: -335544, z: 1000, expX: 9, expY: -9, expZErr: 0, expSat: 0};
        vecs[1] = '{xs: 0, ys: 524287, z: 524287, expX: 0, expY: 8191, expZErr: 0, expSat: 0};
        vecs[4] = '{xs: -524288, ys: 524287, z: 524287, expX: -8191, expY: 8191, expZErr: 0, expSat: 0};
        vecs[5] = '{xs: 65536, ys: -32768, z: 512, expX: 1, expY: 0, expZErr: 0, expSat: 0};
`endif
        vecs[2] = '{xs: 1000, ys: 1000, z: 0, expX: 0, expY: 0, expZErr: 1, expSat: 0};
        vecs[3] = '{xs: 1000, ys: -1000, z: -5, expX: 0, expY: 0, expZErr: 1, expSat: 0};
        vecs[6] = '{xs: 3, ys: -7, z: 1, expX: 0, expY: 0, expZErr: 0, expSat: 0};
        satVec  = '{xs: 524287, ys: -524288, z: 524287, expX: 524287, expY: -524287, expZErr: 0, expSat: 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset inReady", inReadyA, 1);
        checkOutput("reset outValid", outValidA, 0);
        checkOutput("reset xOut", xOutA, 0);
        checkOutput("reset yOut", yOutA, 0);
        checkOutput("reset zErr", zErrA, 0);
        checkOutput("reset sat", satA, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, vecs[i].xs, vecs[i].ys, vecs[i].z, lat);
            checkResult($sformatf("vec%0d", i), 1'b0, vecs[i], lat);
        end

        applyStimulus(1'b1, satVec.xs, satVec.ys, satVec.z, lat);
        checkResult("fraction8 sat", 1'b1, satVec, lat);

        // Downstream stall: results and handshake must hold steady.
        outReadyA = 1'b0;
        applyStimulus(1'b0, vecs[0].xs, vecs[0].ys, vecs[0].z, lat);
        checkResult("stall", 1'b0, vecs[0], lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("stall outValid", outValidA, 1);
            checkOutput("stall inReady", inReadyA, 0);
            checkOutput("stall xOut", xOutA, vecs[0].expX);
            checkOutput("stall yOut", yOutA, vecs[0].expY);
        end
        @(negedge clk);
        outReadyA = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release outValid", outValidA, 0);
        checkOutput("release inReady", inReadyA, 1);
        applyStimulus(1'b0, vecs[1].xs, vecs[1].ys, vecs[1].z, lat);
        checkResult("after stall", 1'b0, vecs[1], lat);

        // Reset in the middle of the multiply must discard the operation.
        applyStimulus(1'b0, vecs[0].xs, vecs[0].ys, vecs[0].z, lat);
        checkResult("pre-abort", 1'b0, vecs[0], lat);
        @(negedge clk);
        while (!inReadyA) @(negedge clk);
        xsIn = vecs[5].xs;
        ysIn = vecs[5].ys;
        zIn  = vecs[5].z;
        inValidA = 1'b1;
        @(posedge clk);
        #1;
        inValidA = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort outValid", outValidA, 0);
        checkOutput("abort xOut", xOutA, 0);
        checkOutput("abort yOut", yOutA, 0);
        checkOutput("abort inReady", inReadyA, 1);
        @(negedge clk);
        reset = 1'b0;
        seenValid = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (outValidA) seenValid++;
        end
        checkOutput("abort no stray result", seenValid, 0);
        applyStimulus(1'b0, vecs[4].xs, vecs[4].ys, vecs[4].z, lat);
        checkResult("post-abort", 1'b0, vecs[4], lat);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
